// File: rtl/carry_increment_adder_cla.sv
// Registered carry-increment adder: BLOCK-bit CLA sections, upper sections add with carry-in 0
// and are conditionally incremented by the section carry chain. Optional overflow: CIA_CLA_OVF_EN.
module carry_increment_adder_cla #(
    parameter int WIDTH = 8,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef CIA_CLA_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int NSEC = (WIDTH + BLOCK - 1) / BLOCK;

    // Lookahead section of n live bits: every carry is a flat sum of products
    // over g/p, so no carry ripples from bit to bit. Returns {carry into bit n, sum}.
    function automatic logic [BLOCK:0] cla_sec(input logic [BLOCK-1:0] x,
                                               input logic [BLOCK-1:0] y,
                                               input logic             cin,
                                               input int               n);
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK-1:0] s;
        logic [BLOCK:0]   c;
        logic             acc;
        logic             term;
        logic             cout;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < BLOCK; i++) begin
            acc = cin;
            for (int k = 0; k <= i; k++) acc = acc & p[k];
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) term = term & p[k];
                acc = acc | term;
            end
            c[i+1] = acc;
        end
        s    = p ^ c[BLOCK-1:0];
        cout = 1'b0;
        for (int i = 0; i <= BLOCK; i++) begin
            if (i == n) cout = c[i];
        end
        for (int i = 0; i < BLOCK; i++) begin
            if (i >= n) s[i] = 1'b0;
        end
        return {cout, s};
    endfunction

    logic [NSEC*BLOCK-1:0] a_pad;
    logic [NSEC*BLOCK-1:0] b_pad;
    logic [NSEC:1]         sec_c;
    logic [WIDTH-1:0]      sum_d;
    logic                  cout_d;

    always_comb begin
        a_pad            = '0;
        b_pad            = '0;
        a_pad[WIDTH-1:0] = a;
        b_pad[WIDTH-1:0] = b;
    end

    genvar k;
    for (k = 0; k < NSEC; k++) begin : g_sec
        localparam int LO = k * BLOCK;
        localparam int N  = ((WIDTH - LO) < BLOCK) ? (WIDTH - LO) : BLOCK;

        logic [BLOCK-1:0] xa;
        logic [BLOCK-1:0] xb;
        logic [BLOCK:0]   r;

        assign xa = a_pad[LO +: BLOCK];
        assign xb = b_pad[LO +: BLOCK];

        if (k == 0) begin : g_base
            assign r               = cla_sec(xa, xb, carry_in, N);
            assign sum_d[LO +: N]  = r[N-1:0];
            assign sec_c[1]        = r[BLOCK];
        end else begin : g_inc
            logic [N-1:0] ps;
            logic         pc;
            logic         bp;
            assign r      = cla_sec(xa, xb, 1'b0, N);
            assign ps     = r[N-1:0];
            assign pc     = r[BLOCK];
            assign bp     = &(xa[N-1:0] ^ xb[N-1:0]);
            // Incoming carry only increments the pre-computed sum; the chain itself is one AND-OR per section.
            assign sum_d[LO +: N] = ps + N'(sec_c[k]);
            assign sec_c[k+1]     = pc | (bp & sec_c[k]);
        end

        if (N < BLOCK) begin : g_trim
            logic trim_unused;
            assign trim_unused = ^r[BLOCK-1:N];
        end
    end

    assign cout_d = sec_c[NSEC];

    logic             vld_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

`ifdef CIA_CLA_OVF_EN
    logic ovf_d;
    logic ovf_q;
    assign ovf_d = (a[WIDTH-1] == b[WIDTH-1]) & (sum_d[WIDTH-1] != a[WIDTH-1]);
`endif

    // Output register: data loads only when qualified, so unqualified inputs never disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
`ifdef CIA_CLA_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
`ifdef CIA_CLA_OVF_EN
                ovf_q  <= ovf_d;
`endif
            end
        end
    end

    assign out_valid = vld_q;
    assign sum       = sum_q;
    assign carry_out = cout_q;
`ifdef CIA_CLA_OVF_EN
    assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_carry_increment_adder_cla.sv
// Directed and sweep bench for carry_increment_adder_cla at 8/4, 13/4 and 16/3.
module tb_carry_increment_adder_cla;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        cin;
    logic [7:0]  a8, b8, s8;
    logic [12:0] a13, b13, s13;
    logic [15:0] a16, b16, s16;
    logic        co8, co13, co16;
    logic        vo8, vo13, vo16;
`ifdef CIA_CLA_OVF_EN
    logic        ov8, ov13, ov16;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    carry_increment_adder_cla #(.WIDTH(8), .BLOCK(4)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8), .b(b8), .carry_in(cin),
        .out_valid(vo8), .sum(s8), .carry_out(co8)
`ifdef CIA_CLA_OVF_EN
        , .overflow(ov8)
`endif
    );

    carry_increment_adder_cla #(.WIDTH(13), .BLOCK(4)) u_w13 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a13), .b(b13), .carry_in(cin),
        .out_valid(vo13), .sum(s13), .carry_out(co13)
`ifdef CIA_CLA_OVF_EN
        , .overflow(ov13)
`endif
    );

    carry_increment_adder_cla #(.WIDTH(16), .BLOCK(3)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a16), .b(b16), .carry_in(cin),
        .out_valid(vo16), .sum(s16), .carry_out(co16)
`ifdef CIA_CLA_OVF_EN
        , .overflow(ov16)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input logic [7:0] es, input logic ec, input logic ev);
        check({tag, ".sum"}, 32'(s8), 32'(es));
        check({tag, ".cout"}, 32'(co8), 32'(ec));
        check({tag, ".vld"}, 32'(vo8), 32'(ev));
    endtask

    logic [8:0]  e8;
    logic [13:0] e13;
    logic [16:0] e16;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        cin      = 1'b0;
        a8 = '0;  b8 = '0;
        a13 = '0; b13 = '0;
        a16 = '0; b16 = '0;
        #2;
        check8("reset", 8'h00, 1'b0, 1'b0);
        check("reset.vld13", 32'(vo13), 32'd0);
        check("reset.vld16", 32'(vo16), 32'd0);
`ifdef CIA_CLA_OVF_EN
        check("reset.ovf", 32'(ov8), 32'd0);
`endif
        #10;
        rst_n = 1'b1;

        in_valid = 1'b1;
        a8 = 8'h1B; b8 = 8'h35; cin = 1'b0;
        a13 = 13'h1234; b13 = 13'h0DCB;
        a16 = 16'h1234; b16 = 16'h4321;
        tick();
        check8("add1B35", 8'h50, 1'b0, 1'b1);
        check("w13.sum", 32'(s13), 32'h1FFF);
        check("w13.cout", 32'(co13), 32'd0);
        check("w16.sum", 32'(s16), 32'h5555);
        check("w16.cout", 32'(co16), 32'd0);
`ifdef CIA_CLA_OVF_EN
        check("add1B35.ovf", 32'(ov8), 32'd0);
`endif

        a8 = 8'hFF; b8 = 8'h01; cin = 1'b1;
        a13 = 13'h1FFF; b13 = 13'h0000;
        a16 = 16'h1234; b16 = 16'h4321;
        tick();
        check8("addFF01c", 8'h01, 1'b1, 1'b1);
        check("w13c.sum", 32'(s13), 32'h0000);
        check("w13c.cout", 32'(co13), 32'd1);
        check("w16c.sum", 32'(s16), 32'h5556);

        a8 = 8'hFF; b8 = 8'h00; cin = 1'b1;
        a16 = 16'hFFFF; b16 = 16'h0000;
        tick();
        check8("addFF00c", 8'h00, 1'b1, 1'b1);
        check("w16f.sum", 32'(s16), 32'h0000);
        check("w16f.cout", 32'(co16), 32'd1);

        a8 = 8'h80; b8 = 8'h80; cin = 1'b0;
        tick();
        check8("add8080", 8'h00, 1'b1, 1'b1);
`ifdef CIA_CLA_OVF_EN
        check("add8080.ovf", 32'(ov8), 32'd1);
`endif

        a8 = 8'h7F; b8 = 8'h01; cin = 1'b0;
        tick();
        check8("add7F01", 8'h80, 1'b0, 1'b1);
`ifdef CIA_CLA_OVF_EN
        check("add7F01.ovf", 32'(ov8), 32'd1);
`endif

        a8 = 8'hAA; b8 = 8'h55; cin = 1'b1;
        tick();
        check8("addAA55c", 8'h00, 1'b1, 1'b1);

        a8 = 8'h1B; b8 = 8'h35; cin = 1'b0;
        tick();
        check8("recap", 8'h50, 1'b0, 1'b1);

        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a8  = (i == 1) ? 8'hxx : 8'(i * 37 + 5);
            b8  = (i == 1) ? 8'hxx : 8'hF0;
            cin = (i == 1) ? 1'bx : 1'b1;
            tick();
            check8("hold", 8'h50, 1'b0, 1'b0);
        end

        in_valid = 1'b1;
        a8 = 8'hAA; b8 = 8'h55; cin = 1'b1;
        tick();
        check8("prerst", 8'h00, 1'b1, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check8("asyncrst", 8'h00, 1'b0, 1'b0);
`ifdef CIA_CLA_OVF_EN
        check("asyncrst.ovf", 32'(ov8), 32'd0);
`endif
        a8 = 8'h0F; b8 = 8'h01; cin = 1'b0;
        tick();
        check8("rstwins", 8'h00, 1'b0, 1'b0);
        #3;
        rst_n = 1'b1;
        tick();
        check8("postrst", 8'h10, 1'b0, 1'b1);

        for (int i = 0; i < 10000; i++) begin
            a8  = 8'($urandom);  b8  = 8'($urandom);
            a13 = 13'($urandom); b13 = 13'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom);
            cin = 1'($urandom);
            e8  = {1'b0, a8} + {1'b0, b8} + 9'(cin);
            e13 = {1'b0, a13} + {1'b0, b13} + 14'(cin);
            e16 = {1'b0, a16} + {1'b0, b16} + 17'(cin);
            tick();
            check("sw8", {co8, s8}, 32'(e8));
            check("sw13", {co13, s13}, 32'(e13));
            check("sw16", {co16, s16}, 32'(e16));
            check("swvld", {vo8, vo13, vo16}, 32'b111);
`ifdef CIA_CLA_OVF_EN
            check("sw8.ovf", 32'(ov8), 32'((a8[7] == b8[7]) && (e8[7] != a8[7])));
`endif
        end

        in_valid = 1'b0;
        tick();
        check("idle.vld", {vo8, vo13, vo16}, 32'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
